// File: rtl/uart_tx_fifo.sv
// Byte FIFO between a host and the UART transmitter, first-word-fall-through head.
// Optional sticky overflow flag is enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_valid,
    input  logic [7:0]                 wr_data,
    output logic                       wr_ready,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    input  logic                       tx_ready,
    output logic [$clog2(DEPTH)+1-1:0] level,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       overflow,
    input  logic                       ovf_clear
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr_ready_q, tx_valid_q, empty_q, afull_q;
    logic          do_wr, do_rd;

    // Handshakes use the registered flags, so a full FIFO rejects a write even when a read frees a slot.
    always_comb begin
        do_wr    = wr_valid & wr_ready_q;
        do_rd    = tx_valid_q & tx_ready;
        wr_ptr_d = do_wr ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(do_wr) - LW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            wr_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            wr_ready_q <= (level_d != LW'(DEPTH));
            tx_valid_q <= (level_d != '0);
            empty_q    <= (level_d == '0);
            afull_q    <= (level_d >= LW'(AFULL_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !reset) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = mem_q[rd_ptr_q];
    assign level       = level_q;
    assign empty       = empty_q;
    assign almost_full = afull_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    // Set is checked before clear so a simultaneous set and clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_valid && !wr_ready_q) begin
            ovf_q <= 1'b1;
        end else if (ovf_clear) begin
            ovf_q <= 1'b0;
        end
    end

    assign overflow = ovf_q;
`else
    logic unused_ovf_clear;

    assign unused_ovf_clear = ovf_clear;
    assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised bench for uart_tx_fifo against a queue-based model of the FIFO rules.
// Overflow expectations follow UART_TX_FIFO_OVF_EN when it is defined for the build.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [4:0] level;
    logic       empty;
    logic       almost_full;
    logic       overflow;
    logic       ovf_clear;

    uart_tx_fifo #(.DEPTH(16), .AFULL_LEVEL(12)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .level      (level),
        .empty      (empty),
        .almost_full(almost_full),
        .overflow   (overflow),
        .ovf_clear  (ovf_clear)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    byte unsigned model_q[$];
    bit           model_ovf     = 1'b0;
    bit           model_rst_prev = 1'b1;
    int unsigned  n_sent = 0;
    int unsigned  n_recv = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned sz;
        sz = model_q.size();
        check_eq({tag, ".wr_ready"}, 32'(wr_ready), 32'(!model_rst_prev && sz != 16));
        check_eq({tag, ".tx_valid"}, 32'(tx_valid), 32'(sz != 0));
        if (sz != 0)
            check_eq({tag, ".tx_data"}, 32'(tx_data), 32'(model_q[0]));
        check_eq({tag, ".level"}, 32'(level), sz);
        check_eq({tag, ".empty"}, 32'(empty), 32'(sz == 0));
        check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(sz >= 12));
`ifdef UART_TX_FIFO_OVF_EN
        check_eq({tag, ".overflow"}, 32'(overflow), 32'(model_ovf));
`else
        check_eq({tag, ".overflow"}, 32'(overflow), 32'd0);
`endif
    endtask

    // Called just after a falling edge; applies inputs for one rising edge and checks the result.
    task automatic step(input string tag, input bit wv, input byte unsigned wd,
                        input bit tr, input bit clr);
        bit accept;
        bit can_wr;
        reset     = 1'b0;
        wr_valid  = wv;
        wr_data   = wd;
        tx_ready  = tr;
        ovf_clear = clr;
        can_wr = !model_rst_prev && model_q.size() != 16;
        accept = wv && can_wr;
        if (wv && !can_wr) model_ovf = 1'b1;
        else if (clr)      model_ovf = 1'b0;
        if (tr && model_q.size() != 0) begin
            void'(model_q.pop_front());
            n_recv++;
        end
        if (accept) begin
            model_q.push_back(wd);
            n_sent++;
        end
        model_rst_prev = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        reset     = 1'b1;
        wr_valid  = 1'b1;
        wr_data   = 8'hEE;
        tx_ready  = 1'b1;
        ovf_clear = 1'b0;
        model_q.delete();
        model_ovf      = 1'b0;
        model_rst_prev = 1'b1;
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset     = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        tx_ready  = 1'b0;
        ovf_clear = 1'b0;
        @(negedge clk);
        do_reset("reset");
        step("post_reset", 1'b0, 8'h00, 1'b0, 1'b0);

        step("wr55", 1'b1, 8'h55, 1'b0, 1'b0);
        step("hold55", 1'b0, 8'h00, 1'b0, 1'b0);
        step("drain55", 1'b0, 8'h00, 1'b1, 1'b0);
        step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++)
            step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'hAA, 1'b1, 1'b0);
        step("ovf_hold", 1'b0, 8'h00, 1'b0, 1'b0);
        step("refill", 1'b1, 8'h10, 1'b0, 1'b0);
        step("set_and_clr", 1'b1, 8'hBB, 1'b0, 1'b1);
        step("ovf_clear", 1'b0, 8'h00, 1'b0, 1'b1);

        while (model_q.size() != 0)
            step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 60; i++)
            step("stream", 1'b1, 8'($urandom), 1'($urandom % 2), 1'b0);
        check_eq("stream_wraps", 32'(n_sent >= 40 && n_recv >= 32), 32'd1);

        for (int i = 0; i < 400; i++)
            step("random", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));

        while (model_q.size() != 0)
            step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            step("lvl5", 1'b1, 8'($urandom), 1'b0, 1'b0);
        step("wr_rd_5", 1'b1, 8'h77, 1'b1, 1'b0);
        do_reset("mid_reset");
        step("after_reset", 1'b1, 8'h12, 1'b0, 1'b0);
        step("after_reset_wr", 1'b1, 8'h34, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of byte entries; it SHALL be a power of two, at least 4.
REQ-002 The block SHALL have parameter AFULL_LEVEL, default 12, fill level at or above which almost_full asserts; legal range 1..DEPTH.
REQ-003 clk  input  1  clock; all logic SHALL be on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 wr_valid  input  1  host offers a byte.
REQ-006 wr_data  input  8  byte offered by the host.
REQ-007 wr_ready  output  1  FIFO accepts a byte this cycle.
REQ-008 tx_valid  output  1  head byte is available to the transmitter.
REQ-009 tx_data  output  8  head byte, first-word-fall-through.
REQ-010 tx_ready  input  1  transmitter takes the head byte; the integrator SHALL drive it from the transmitter's ready AND en.
REQ-011 level  output  $clog2(DEPTH)+1  current number of stored bytes.
REQ-012 empty  output  1  level == 0.
REQ-013 almost_full  output  1  level >= AFULL_LEVEL.
REQ-014 overflow  output  1  sticky flag set by a rejected write.
REQ-015 ovf_clear  input  1  clears overflow.

Function
REQ-016 A write SHALL occur on a cycle with wr_valid && wr_ready; wr_data SHALL be stored at the write pointer, and the pointer SHALL advance by one.
REQ-017 A read SHALL occur on a cycle with tx_valid && tx_ready; the read pointer SHALL advance by one.
REQ-018 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-019 wr_ready, tx_valid, level, empty and almost_full SHALL be registered and SHALL reflect the state after the current cycle's write and read.
REQ-020 A byte written in cycle N SHALL appear on tx_data with tx_valid=1 in cycle N+1 if the FIFO was empty; write-to-valid latency SHALL be 1 cycle.
REQ-021 tx_data SHALL equal the entry at the read pointer and SHALL hold stable while tx_valid=1 and tx_ready=0.
REQ-022 wr_ready SHALL be 0 when level == DEPTH; a write SHALL NOT be accepted when full, even if a read occurs in the same cycle.
REQ-023 A simultaneous write and read SHALL leave level unchanged and advance both pointers.
REQ-024 tx_ready while tx_valid=0 SHALL have no effect.
REQ-025 Bytes SHALL leave in exactly the order they were accepted, with no loss or duplication.
REQ-026 The block SHALL NOT assert tx_valid with stale data after a pointer wrap.

Reset
REQ-027 While reset=1, the block SHALL drive wr_ready=0, tx_valid=0, level=0, empty=1, almost_full=0 and overflow=0, and SHALL clear both pointers.
REQ-028 wr_ready SHALL rise to 1 in the first cycle after reset deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all stored bytes; storage contents need not be cleared.
REQ-030 Reset SHALL take priority over every other input.

Configuration
REQ-031 With macro UART_TX_FIFO_OVF_EN defined, overflow SHALL set on any cycle with wr_valid=1 and wr_ready=0 outside reset.
REQ-032 With UART_TX_FIFO_OVF_EN defined, overflow SHALL stay set until ovf_clear=1; if set and clear occur in the same cycle, set SHALL win.
REQ-033 Without UART_TX_FIFO_OVF_EN, overflow SHALL be tied to 0, ovf_clear SHALL be ignored, and the port list SHALL be unchanged.

Verification
REQ-034 Reset, then write 0x55 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0x55, level=1, empty=0.
REQ-035 DEPTH=16: write 16 bytes 0x00..0x0F with tx_ready=0 -> wr_ready=0 and level=16 after the 16th write; almost_full=1 from level 12.
REQ-036 Full FIFO, drive wr_valid=1 with 0xAA and tx_ready=1 for one cycle -> 0xAA is rejected, level=15, head becomes 0x01; with the macro defined, overflow=1 until ovf_clear.
REQ-037 Stream 40 bytes with random tx_ready and continuous writes -> output sequence equals input sequence across at least two pointer wraps.
REQ-038 Level=5, simultaneous write and read -> level stays 5 and head advances; then assert reset -> next cycle level=0, tx_valid=0, empty=1.
REQ-039 Connected to the UART transmitter at 50 MHz / 115200 baud, queue 0x41 and 0x42 -> the line carries two back-to-back frames in order.
